// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the async imem ROM and
// registers each word into a valid/ready stage toward decode.
module imem_fetch_ctrl #(
  parameter int unsigned        ADDR_W    = 6,
  parameter int unsigned        DATA_W    = 32,
  parameter logic [DATA_W-1:0]  HALT_WORD = '0,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_q,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t              r_state, w_state_n;
  logic [ADDR_W-1:0]   r_pc, w_pc_n;
  logic                r_valid, w_valid_n;
  logic [DATA_W-1:0]   r_instr, w_instr_n;
  logic [ADDR_W-1:0]   r_ipc, w_ipc_n;
  logic [31:0]         r_cnt, w_cnt_n;
  logic                w_hs, w_ld;

  assign imem_addr   = r_pc;
  assign instr_valid = r_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_ipc;
  assign halted      = (r_state == S_HALT);
  assign fetch_cnt   = r_cnt;

  assign w_hs = r_valid & instr_ready;
  assign w_ld = (r_state == S_RUN) & fetch_en & ~br_valid & (~r_valid | instr_ready);

  always_comb begin
    w_state_n = r_state;
    w_pc_n    = r_pc;
    w_valid_n = r_valid;
    w_instr_n = r_instr;
    w_ipc_n   = r_ipc;
    w_cnt_n   = r_cnt + (w_hs ? 32'd1 : 32'd0);
    // Redirect flushes the held word, but a same-cycle handshake is still counted above.
    if (br_valid) begin
      w_pc_n    = br_target;
      w_valid_n = 1'b0;
      w_state_n = S_RUN;
    end else if (w_ld) begin
      if (imem_q != HALT_WORD) begin
        w_instr_n = imem_q;
        w_ipc_n   = r_pc;
        w_valid_n = 1'b1;
        w_pc_n    = r_pc + ADDR_W'(1);
      end else begin
        w_state_n = S_HALT;
        w_valid_n = 1'b0;
      end
    end else if (w_hs) begin
      w_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_pc    <= RESET_PC;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_n;
      r_pc    <= w_pc_n;
      r_valid <= w_valid_n;
      r_instr <= w_instr_n;
      r_ipc   <= w_ipc_n;
      r_cnt   <= w_cnt_n;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset, fetch_en, br_valid, instr_ready;
  logic [5:0]  br_target, imem_addr, instr_pc;
  logic [31:0] imem_q, instr, fetch_cnt;
  logic        instr_valid, halted;

  logic [31:0] rom [64];
  bit          stub = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: decode-side output stage as a queue of {pc, word}, at most one deep
  logic [37:0] m_q[$];
  logic [5:0]  m_pc;
  bit          m_halt;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  always_comb imem_q = stub ? 32'h8b1f03ff : rom[imem_addr];

  imem_fetch_ctrl #(.ADDR_W(6), .DATA_W(32), .HALT_WORD(32'h0), .RESET_PC(6'd0)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_q(imem_q), .br_valid(br_valid), .br_target(br_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .halted(halted), .fetch_cnt(fetch_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] word_at(input logic [5:0] a);
    return stub ? 32'h8b1f03ff : rom[a];
  endfunction

  task automatic model_step(input bit rst, input bit en, input bit br,
                            input logic [5:0] tgt, input bit rdy);
    bit accepted, fetch;
    logic [31:0] w;
    if (!rst) begin
      m_q.delete(); m_pc = 6'd0; m_halt = 0; m_cnt = 0;
      return;
    end
    accepted = (m_q.size() != 0) && rdy;
    fetch    = !m_halt && en && !br && (m_q.size() == 0 || rdy);
    if (accepted) begin
      m_cnt = m_cnt + 1;
      void'(m_q.pop_front());
    end
    if (br) begin
      m_q.delete(); m_pc = tgt; m_halt = 0;
    end else if (fetch) begin
      w = word_at(m_pc);
      if (w == 32'h0) m_halt = 1;
      else begin
        m_q.push_back({m_pc, w});
        m_pc = m_pc + 6'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_addr", {26'd0, imem_addr}, {26'd0, m_pc});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
    chk("halted", {31'd0, halted}, {31'd0, m_halt});
    chk("fetch_cnt", fetch_cnt, m_cnt);
    if (m_q.size() != 0) begin
      chk("instr", instr, m_q[0][31:0]);
      chk("instr_pc", {26'd0, instr_pc}, {26'd0, m_q[0][37:32]});
    end
  endtask

  // Drive inputs for the next edge, advance the model, then check after the edge.
  task automatic tick(input bit rst, input bit en, input bit br,
                      input logic [5:0] tgt, input bit rdy);
    reset = rst; fetch_en = en; br_valid = br; br_target = tgt; instr_ready = rdy;
    model_step(rst, en, br, tgt, rdy);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    tick(0, 1, 0, 6'd0, 1);
    tick(0, 1, 0, 6'd0, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = (i < 47) ? (32'h8b000000 | 32'(i)) : 32'h0;
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[29] = 32'hb4000040;
    rom[46] = 32'hb400001f;

    // Full program run to halt
    do_reset();
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_cnt", fetch_cnt, 32'd0);
    tick(1, 1, 0, 6'd0, 1);
    chk("t1_e1_instr", instr, 32'hf8000001);
    chk("t1_e1_pc", {26'd0, instr_pc}, 32'd0);
    tick(1, 1, 0, 6'd0, 1);
    chk("t1_e2_instr", instr, 32'hf8008002);
    chk("t1_e2_pc", {26'd0, instr_pc}, 32'd1);
    for (int e = 3; e <= 47; e++) tick(1, 1, 0, 6'd0, 1);
    chk("t1_e47_instr", instr, 32'hb400001f);
    chk("t1_e47_pc", {26'd0, instr_pc}, 32'd46);
    tick(1, 1, 0, 6'd0, 1);
    chk("t1_halted", {31'd0, halted}, 32'd1);
    chk("t1_cnt", fetch_cnt, 32'd47);
    chk("t1_valid", {31'd0, instr_valid}, 32'd0);
    for (int e = 0; e < 3; e++) tick(1, 1, 0, 6'd0, 1);
    chk("t1_pc_frozen", {26'd0, imem_addr}, 32'd47);

    // Leave HALT via redirect
    tick(1, 1, 1, 6'd0, 1);
    chk("t6_unhalt", {31'd0, halted}, 32'd0);
    tick(1, 1, 0, 6'd0, 1);
    chk("t6_instr", instr, 32'hf8000001);
    chk("t6_pc", {26'd0, instr_pc}, 32'd0);

    // Backpressure
    do_reset();
    tick(1, 1, 0, 6'd0, 1);
    for (int e = 0; e < 3; e++) begin
      tick(1, 1, 0, 6'd0, 0);
      chk("t2_hold_instr", instr, 32'hf8000001);
      chk("t2_hold_addr", {26'd0, imem_addr}, 32'd1);
      chk("t2_hold_cnt", fetch_cnt, 32'd0);
    end
    tick(1, 1, 0, 6'd0, 1);
    chk("t2_next", instr, 32'hf8008002);

    // Redirect while pc5 word is held
    do_reset();
    for (int e = 0; e < 6; e++) tick(1, 1, 0, 6'd0, 1);
    chk("t3_pc5", {26'd0, instr_pc}, 32'd5);
    tick(1, 1, 1, 6'd29, 0);
    chk("t3_flush", {31'd0, instr_valid}, 32'd0);
    tick(1, 1, 0, 6'd0, 1);
    chk("t3_instr", instr, 32'hb4000040);
    chk("t3_pc", {26'd0, instr_pc}, 32'd29);
    chk("t3_cnt", fetch_cnt, 32'd5);

    // Reset mid-run
    do_reset();
    for (int e = 0; e < 11; e++) tick(1, 1, 0, 6'd0, 1);
    tick(0, 1, 0, 6'd0, 1);
    chk("t4_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_addr", {26'd0, imem_addr}, 32'd0);
    chk("t4_cnt", fetch_cnt, 32'd0);
    tick(1, 1, 0, 6'd0, 1);
    chk("t4_instr", instr, 32'hf8000001);

    // PC wrap with a ROM that never yields the halt word
    stub = 1'b1;
    do_reset();
    for (int e = 0; e < 64; e++) tick(1, 1, 0, 6'd0, 1);
    chk("t5_pc63", {26'd0, instr_pc}, 32'd63);
    tick(1, 1, 0, 6'd0, 1);
    chk("t5_pc0", {26'd0, instr_pc}, 32'd0);
    chk("t5_nohalt", {31'd0, halted}, 32'd0);
    for (int e = 0; e < 200; e++) tick(1, 1, 0, 6'd0, ($urandom_range(0, 3) != 0));
    stub = 1'b0;

    // Randomized traffic
    do_reset();
    for (int e = 0; e < 4000; e++) begin
      tick(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 6) != 0),
           ($urandom_range(0, 24) == 0),
           6'($urandom_range(0, 63)),
           ($urandom_range(0, 9) < 7));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
